uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface

REQ-001 Parameter CLKS_PER_BIT, default 868, gives clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.

REQ-002 Parameter FIFO_DEPTH, default 4, gives the receive FIFO depth in bytes; it SHALL be a power of 2, from 2 to 64.

REQ-003 Port clk, input, 1 bit: clock; all state changes on its rising edge.

REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.

REQ-005 Port rx_in, input, 1 bit: asynchronous serial line; idle high; 8N1 framing, LSB first.

REQ-006 Port rd_en, input, 1 bit: pops the FIFO head when valid=1.

REQ-007 Port dout, output, 8 bits: FIFO head byte (first-word fall-through).

REQ-008 Port valid, output, 1 bit: FIFO non-empty.

REQ-009 Port level, output, log2(FIFO_DEPTH)+1 bits: number of bytes stored.

REQ-010 Port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples 0.

REQ-011 Port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

REQ-012 Port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function

REQ-013 rx_in SHALL pass through a 2-flop synchronizer initialised to 1; rx_s is the second flop.

REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; a counter of at least 16 bits SHALL time the bit periods.

REQ-015 IDLE: a start is detected on the edge where rx_s=0 and its previous value was 1 (edge cycle t0); the FSM goes to START with the counter cleared.
- A line held low after a frame SHALL NOT retrigger.

REQ-016 START: sample rx_s at t0+floor(CLKS_PER_BIT/2).
- 0 → DATA, bit index 0.
- 1 → false start; return to IDLE with no output.

REQ-017 DATA: bit i (0..7) SHALL be sampled at t0+floor(CLKS_PER_BIT/2)+(i+1)*CLKS_PER_BIT.
- Shift into bit i of the byte, LSB first.
- After bit 7 → STOP.

REQ-018 STOP: sample at t0+floor(CLKS_PER_BIT/2)+9*CLKS_PER_BIT, then go to IDLE in the same edge.
- This allows back-to-back frames with a single stop bit.

REQ-019 Stop=1: push the byte into the FIFO. Stop=0: assert frame_err for 1 cycle and discard the byte.

REQ-020 A push SHALL be visible at the outputs on the cycle after the stop-sample edge (valid, level, and dout if the FIFO was empty).

REQ-021 rd_en with valid=1: remove the head at the edge; the next head appears on dout the following cycle.
- rd_en with valid=0 SHALL be ignored.

REQ-022 Push and pop in the same cycle: level unchanged.
- If the FIFO is full, the push SHALL be accepted and no overrun asserted.

REQ-023 Push while full without a pop: drop the byte, pulse overrun for 1 cycle, leave the FIFO contents unchanged.

REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or go below 0.

REQ-025 dout SHALL be 0x00 while the FIFO is empty.

Reset

REQ-026 While rst=1:
- FSM=IDLE, counter=0, synchronizer flops=1.
- FIFO emptied.
- dout=0x00, valid=0, level=0, frame_err=0, overrun=0, busy=0.

REQ-027 Reset asserted mid-frame SHALL abandon the frame with no push and no pulses.
- Reception resumes at the next detected falling edge after rst deasserts.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)

REQ-028 Send frame 0x55 → one cycle after the stop sample: valid=1, dout=0x55, level=1. Then rd_en for 1 cycle → valid=0, level=0.

REQ-029 Drive rx_in low for 4 cycles, then high → no push, busy returns to 0 after the START sample, frame_err=0.

REQ-030 Send 0xA3 with stop bit 0 → frame_err high for exactly 1 cycle, level=0. Then hold the line low for 40 cycles → no new frame starts.

REQ-031 Send 0x01..0x05 back-to-back with no reads → FIFO holds 0x01..0x04, level=4, and overrun pulses once at the 5th stop sample. Then send 0x06 while rd_en pulses in the stop-sample cycle → level stays 4, no overrun, reads give 0x02, 0x03, 0x04, 0x06.

REQ-032 Assert rst for 2 cycles after data bit 3 of frame 0x3C → all outputs at reset values. Then send 0xC3 → dout=0xC3, level=1.

REQ-033 Send 0x00 then 0xFF with one stop bit and no idle gap → both received in order, frame_err=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word fall-through byte FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_in,
    input  logic                        rd_en,
    output logic [7:0]                  dout,
    output logic                        valid,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Counter terminal values: the counter restarts at 0 on the edge after each sample,
    // so the sample edge is the one that sees terminal-1.
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          sync1;
    logic          rx_s;
    logic          rx_prev;
    state_t        state;
    logic [15:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high at reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    // Receiver FSM: mid-bit sampling of start, eight data bits and the stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    // Edge-triggered, so a line left low after a bad frame cannot restart us
                    if (!rx_s && rx_prev) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= 16'd0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt            <= 16'd0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt       <= 16'd0;
                        state     <= IDLE;
                        frame_err <= !rx_s;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The push is decoded from the stop-sample edge itself so the byte lands one cycle later
    assign push = (state == STOP) && (cnt == FULL_M1) && rx_s;
    assign busy = (state != IDLE);

    assign valid = (count != '0);
    assign full  = (count == DEPTH_L);
    assign pop   = rd_en && valid;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign wr    = push && (!full || pop);

    // Storage array; no reset needed since dout is gated by valid
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // Pointer, occupancy and overrun bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !wr) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    assign level = count;
    assign dout  = valid ? mem[rd_ptr] : 8'h00;

endmodule
